// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ram_arbiter
//  Purpose  : Two-master Wishbone arbiter in front of a single-port RAM.
//             Round-robin grant on contention, a bounded busy timeout that
//             returns an error, and a mandatory one-cycle idle gap between
//             transactions so the RAM never sees stb held across an ack.
//  Ports    : clk_i, rst_in (sync, active-low)
//             m0_* / m1_* : Wishbone master ports (cyc, stb, we, sel, dat,
//                           adr in; ack, err, dat out)
//             s_*         : shared RAM slave port (cyc, stb, we, sel, dat,
//                           adr out; ack, dat in)
//  Revision : 1.0 - initial release
// ============================================================================
module wb_ram_arbiter #(
    parameter int ADR_W   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic             clk_i,
    input  logic             rst_in,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_sel_i,
    input  logic [31:0]      m0_dat_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic [31:0]      m0_dat_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_sel_i,
    input  logic [31:0]      m1_dat_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic [31:0]      m1_dat_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [3:0]       s_sel_o,
    output logic [31:0]      s_dat_o,
    output logic [ADR_W-1:0] s_adr_o,
    input  logic             s_ack_i,
    input  logic [31:0]      s_dat_i
);

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic       r_grant;    // 0 = master 0 owns the slave, 1 = master 1
    logic       r_last;     // master granted most recently
    logic [7:0] r_cnt;      // BUSY cycles elapsed without a slave ack

    logic w_req0;
    logic w_req1;
    logic w_next;
    logic w_req_g;
    logic w_busy;
    logic w_sel_m1;
    logic w_term_ok;
    logic w_ack;
    logic w_err;
    logic w_to_hit;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;

    // On contention the master not served last wins; a lone requester always wins.
    assign w_next  = (w_req0 & w_req1) ? ~r_last : w_req1;
    assign w_req_g = r_grant ? w_req1 : w_req0;

    // Gating with rst_in keeps the slave port and terminations quiet in the
    // very cycle reset is asserted, not only after it has been sampled.
    assign w_busy   = (r_state == ST_BUSY) & rst_in;
    assign w_sel_m1 = w_busy & r_grant;

    // A termination is only forwarded while the granted master still requests;
    // an abort swallows any ack/err in that cycle.
    assign w_term_ok = w_busy & w_req_g;
    assign w_to_hit  = (r_cnt == c_TO_LAST);
    assign w_ack     = w_term_ok & s_ack_i;
    assign w_err     = w_term_ok & ~s_ack_i & w_to_hit;

    assign m0_ack_o = w_ack & ~r_grant;
    assign m1_ack_o = w_ack &  r_grant;
    assign m0_err_o = w_err & ~r_grant;
    assign m1_err_o = w_err &  r_grant;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Outside BUSY the data-path outputs idle on master 0's inputs so they
    // are always driven; cyc/stb stay low.
    assign s_cyc_o = w_busy & (r_grant ? m1_cyc_i : m0_cyc_i);
    assign s_stb_o = w_busy & (r_grant ? m1_stb_i : m0_stb_i);
    assign s_we_o  = w_sel_m1 ? m1_we_i  : m0_we_i;
    assign s_sel_o = w_sel_m1 ? m1_sel_i : m0_sel_i;
    assign s_dat_o = w_sel_m1 ? m1_dat_i : m0_dat_i;
    assign s_adr_o = w_sel_m1 ? m1_adr_i : m0_adr_i;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant <= w_next;
                        r_last  <= w_next;
                        r_cnt   <= 8'd0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Ack, abort and timeout all return through IDLE, which
                    // drops stb for a cycle before the next grant.
                    if (!w_req_g || s_ack_i || w_to_hit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_ram_arbiter
//  Purpose  : Directed self-checking bench for wb_ram_arbiter with a
//             byte-lane RAM model on the slave port (TIMEOUT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_ram_arbiter;

    localparam int c_ADR_W   = 10;
    localparam int c_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]        m_cyc;
    logic [1:0]        m_stb;
    logic [1:0]        m_we;
    logic [3:0]        m_sel [2];
    logic [31:0]       m_dat [2];
    logic [c_ADR_W-1:0] m_adr [2];

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdat, m1_rdat;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [3:0]  s_sel;
    logic [31:0] s_wdat;
    logic [31:0] s_rdat = 32'd0;
    logic [c_ADR_W-1:0] s_adr;

    logic        r_ram_ack = 1'b0;
    logic        ack_force = 1'b0;
    logic        ack_kill  = 1'b0;
    logic [31:0] ram [0:(1<<c_ADR_W)-1];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign s_ack = (r_ram_ack | ack_force) & ~ack_kill;

    wb_ram_arbiter #(.ADR_W(c_ADR_W), .TIMEOUT(c_TIMEOUT)) u_dut (
        .clk_i    (clk),
        .rst_in   (rst_n),
        .m0_cyc_i (m_cyc[0]),
        .m0_stb_i (m_stb[0]),
        .m0_we_i  (m_we[0]),
        .m0_sel_i (m_sel[0]),
        .m0_dat_i (m_dat[0]),
        .m0_adr_i (m_adr[0]),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m0_dat_o (m0_rdat),
        .m1_cyc_i (m_cyc[1]),
        .m1_stb_i (m_stb[1]),
        .m1_we_i  (m_we[1]),
        .m1_sel_i (m_sel[1]),
        .m1_dat_i (m_dat[1]),
        .m1_adr_i (m_adr[1]),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .m1_dat_o (m1_rdat),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_dat_o  (s_wdat),
        .s_adr_o  (s_adr),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_rdat)
    );

    // RAM model: acks one cycle after cyc&stb, registered read data.
    always @(posedge clk) begin
        if (s_cyc && s_stb && s_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s_sel[b]) ram[s_adr][8*b +: 8] <= s_wdat[8*b +: 8];
            end
        end
        s_rdat    <= ram[s_adr];
        r_ram_ack <= s_cyc & s_stb & ~r_ram_ack;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic we, input logic [c_ADR_W-1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[n] = 1'b1;
        m_stb[n] = 1'b1;
        m_we[n]  = we;
        m_adr[n] = adr;
        m_dat[n] = dat;
        m_sel[n] = sel;
    endtask

    task automatic release_m(input int n);
        m_cyc[n] = 1'b0;
        m_stb[n] = 1'b0;
    endtask

    task automatic reset_dut();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One transfer on master n; ack_cyc is cycles from request to ack, -1 if none.
    task automatic xfer(input int n, input logic we, input logic [c_ADR_W-1:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd, output int ack_cyc);
        rd      = 32'd0;
        ack_cyc = -1;
        step();
        drive(n, we, adr, dat, sel);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if ((n == 0) ? m0_ack : m1_ack) begin
                ack_cyc = c;
                rd = (n == 0) ? m0_rdat : m1_rdat;
                break;
            end
            step();
        end
        step();
        release_m(n);
    endtask

    logic [31:0] ref_mem [0:7];
    logic [1:0]  active;
    int          age [2];
    logic [31:0] rd;
    int          lat;

    initial begin
        for (int i = 0; i < (1 << c_ADR_W); i++) ram[i] = 32'd0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'd0;

        // Reset with both masters requesting: nothing may leave the arbiter.
        rst_n = 1'b0;
        drive(0, 1'b1, 10'h3A5, 32'hA5A5_0001, 4'hC);
        drive(1, 1'b0, 10'h011, 32'h0000_0022, 4'h3);
        step();
        step();
        @(negedge clk);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_acks_errs", {28'd0, m1_err, m1_ack, m0_err, m0_ack}, 32'd0);
        check("rst_s_adr_from_m0", 32'(s_adr), 32'h3A5);
        check("rst_s_dat_from_m0", s_wdat, 32'hA5A5_0001);
        check("rst_s_sel_from_m0", 32'(s_sel), 32'hC);
        step();
        rst_n = 1'b1;
        release_m(0);
        release_m(1);

        // Single write: stb in cycle 1, ack in cycle 2, stb low in cycle 3.
        step();
        drive(0, 1'b1, 10'h005, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        check("wr_c0_stb", 32'(s_stb), 32'd0);
        step();
        @(negedge clk);
        check("wr_c1_stb", 32'(s_stb), 32'd1);
        check("wr_c1_adr", 32'(s_adr), 32'h005);
        check("wr_c1_dat", s_wdat, 32'hDEAD_BEEF);
        check("wr_c1_we", 32'(s_we), 32'd1);
        check("wr_c1_ack", 32'(m0_ack), 32'd0);
        step();
        @(negedge clk);
        check("wr_c2_m0_ack", 32'(m0_ack), 32'd1);
        check("wr_c2_m1_ack", 32'(m1_ack), 32'd0);
        step();
        release_m(0);
        @(negedge clk);
        check("wr_c3_stb", 32'(s_stb), 32'd0);

        xfer(0, 1'b0, 10'h005, 32'd0, 4'hF, rd, lat);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_data", rd, 32'hDEAD_BEEF);
        // Byte-lane write of the two low bytes only.
        xfer(1, 1'b1, 10'h005, 32'h1234_5678, 4'h3, rd, lat);
        check("wr_lane_latency", 32'(lat), 32'd2);
        xfer(0, 1'b0, 10'h005, 32'd0, 4'hF, rd, lat);
        check("rd_lane_data", rd, 32'hDEAD_5678);

        // Contention after reset: m0, m1, m0, m1 acked in cycles 2, 5, 8, 11.
        reset_dut();
        step();
        drive(0, 1'b0, 10'h020, 32'd0, 4'hF);
        drive(1, 1'b0, 10'h021, 32'd0, 4'hF);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("cont_c%0d_m0_ack", c), 32'(m0_ack), 32'((c == 2) || (c == 8)));
            check($sformatf("cont_c%0d_m1_ack", c), 32'(m1_ack), 32'((c == 5) || (c == 11)));
            step();
        end
        release_m(0);
        release_m(1);

        // Abort: m1 drops cyc in cycle 1; injected slave acks are discarded.
        step();
        drive(1, 1'b0, 10'h030, 32'd0, 4'hF);
        step();
        m_cyc[1]  = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        check("abort_c1_s_cyc", 32'(s_cyc), 32'd0);
        check("abort_c1_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        step();
        m_cyc[1] = 1'b1;
        @(negedge clk);
        check("abort_c2_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        check("abort_c2_idle", 32'(s_cyc), 32'd0);
        step();
        ack_force = 1'b0;
        @(negedge clk);
        check("abort_c3_regrant", 32'(s_cyc), 32'd1);
        step();
        @(negedge clk);
        check("abort_c4_m1_ack", 32'(m1_ack), 32'd1);
        step();
        release_m(1);

        // Timeout: slave never acks, err exactly in cycle 4.
        ack_kill = 1'b1;
        step();
        drive(0, 1'b0, 10'h040, 32'd0, 4'hF);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("to_c%0d_m0_err", c), 32'(m0_err), 32'(c == 4));
            check($sformatf("to_c%0d_m0_ack", c), 32'(m0_ack), 32'd0);
            check($sformatf("to_c%0d_m1_err", c), 32'(m1_err), 32'd0);
            step();
        end
        release_m(0);
        step();
        step();
        ack_kill = 1'b0;

        // Ack arriving in the timeout cycle wins over err.
        step();
        ack_kill = 1'b1;
        drive(0, 1'b0, 10'h005, 32'd0, 4'hF);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            step();
        end
        ack_kill  = 1'b0;
        ack_force = 1'b1;
        @(negedge clk);
        check("to_ack_wins_ack", 32'(m0_ack), 32'd1);
        check("to_ack_wins_err", 32'(m0_err), 32'd0);
        step();
        ack_force = 1'b0;
        release_m(0);

        // Reset in cycle 1 of an m0 write; next contention grants m0 first.
        step();
        drive(0, 1'b1, 10'h050, 32'h5555_AAAA, 4'hF);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_c1_ack", 32'(m0_ack), 32'd0);
        check("rstmid_c1_s_cyc", 32'(s_cyc), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1, 1'b0, 10'h051, 32'd0, 4'hF);
        @(negedge clk);
        check("rstmid_c2_s_cyc", 32'(s_cyc), 32'd0);
        check("rstmid_c2_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        step();
        @(negedge clk);
        check("rstmid_c3_s_cyc", 32'(s_cyc), 32'd1);
        check("rstmid_c3_adr_m0", 32'(s_adr), 32'h050);
        step();
        @(negedge clk);
        check("rstmid_c4_m0_ack", 32'(m0_ack), 32'd1);
        check("rstmid_c4_m1_ack", 32'(m1_ack), 32'd0);
        step();
        release_m(0);
        step();
        step();
        @(negedge clk);
        check("rstmid_c7_m1_ack", 32'(m1_ack), 32'd1);
        step();
        release_m(1);

        // Random mixed traffic on addresses 0x100..0x107 against a reference.
        active = 2'b00;
        age[0] = 0;
        age[1] = 0;
        for (int i = 0; i < 340; i++) begin
            step();
            for (int n = 0; n < 2; n++) begin
                if (!active[n]) begin
                    if (i < 300 && $urandom_range(0, 3) != 0) begin
                        drive(n, 1'($urandom_range(0, 1)), 10'h100 + 10'($urandom_range(0, 7)),
                              $urandom, 4'($urandom_range(1, 15)));
                        active[n] = 1'b1;
                        age[n]    = 0;
                    end else begin
                        release_m(n);
                    end
                end else begin
                    age[n]++;
                    if (age[n] > 20) begin
                        check($sformatf("rnd_m%0d_stall", n), 32'(age[n]), 32'd20);
                        active[n] = 1'b0;
                        release_m(n);
                    end
                end
            end
            @(negedge clk);
            check("rnd_no_double_or_err", {28'd0, m0_ack & m1_ack, m0_err, m1_err, 1'b0}, 32'd0);
            for (int n = 0; n < 2; n++) begin
                if ((n == 0) ? m0_ack : m1_ack) begin
                    check($sformatf("rnd_m%0d_ack_active", n), 32'(active[n]), 32'd1);
                    if (m_we[n]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_sel[n][b]) ref_mem[m_adr[n][2:0]][8*b +: 8] = m_dat[n][8*b +: 8];
                        end
                    end else begin
                        check($sformatf("rnd_m%0d_rdata", n), (n == 0) ? m0_rdat : m1_rdat,
                              ref_mem[m_adr[n][2:0]]);
                    end
                    active[n] = 1'b0;
                end
            end
        end
        check("rnd_drained", 32'(active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
